// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: receive-side byte FIFO between a UART receiver core and a
// line-oriented consumer. Collapses CRLF to CR, counts buffered CR-terminated
// lines, flags dropped bytes, and can echo accepted bytes to a TX buffer.
//
// Ports:
//   clk           single clock, rising edge
//   rst           synchronous active-high reset
//   byte_in       received byte, qualified by in_valid (one-cycle strobe)
//   byte_out      byte at the FIFO head (registered), valid when out_ready
//   out_advance   pop request, acts on its rising edge only
//   out_ready     byte_out is valid
//   line_ready    at least one complete CR-terminated line is buffered
//   fill          current byte count (0 .. 2^ADDR_W)
//   overflow      sticky, a byte was dropped because the FIFO was full
//   overflow_clr  clears overflow (a same-cycle drop wins)
//   echo_char     byte to echo, qualified by echo_valid
//   echo_valid    one-cycle strobe, the cycle after an accepted write
//
// Build option: define UART_RX_ECHO_EN to enable the echo path; otherwise
// echo_char and echo_valid are held at 0.

module uart_rx_buffer #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        byte_in,
  input  logic              in_valid,
  output logic [7:0]        byte_out,
  input  logic              out_advance,
  output logic              out_ready,
  output logic              line_ready,
  output logic [ADDR_W:0]   fill,
  output logic              overflow,
  input  logic              overflow_clr,
  output logic [7:0]        echo_char,
  output logic              echo_valid
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [7:0]  CR    = 8'h0D;
  localparam logic [7:0]  LF    = 8'h0A;

  logic [7:0]        mem [DEPTH];

  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [CNT_W-1:0]  fill_q, fill_d;
  logic [CNT_W-1:0]  line_cnt_q, line_cnt_d;
  logic              last_cr_q, last_cr_d;
  logic              adv_q, adv_d;
  logic [7:0]        byte_out_q, byte_out_d;
  logic              out_ready_q, out_ready_d;
  logic              line_ready_q, line_ready_d;
  logic              ovf_q, ovf_d;
  logic [7:0]        echo_char_q, echo_char_d;
  logic              echo_valid_q, echo_valid_d;

  logic full, lf_drop, wr_en, ovf_drop, pop, line_inc, line_dec;

  // Write/pop qualification and next-state computation
  always_comb begin
    full     = (fill_q == CNT_W'(DEPTH));
    // An LF directly following an accepted CR is swallowed, not an overflow
    lf_drop  = in_valid && last_cr_q && (byte_in == LF);
    wr_en    = in_valid && !lf_drop && !full;
    ovf_drop = in_valid && !lf_drop && full;
    pop      = out_advance && !adv_q && (fill_q != '0);
    line_inc = wr_en && (byte_in == CR);
    line_dec = pop && (byte_out_q == CR) && (line_cnt_q != '0);

    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    fill_d       = fill_q;
    line_cnt_d   = line_cnt_q;
    last_cr_d    = last_cr_q;
    adv_d        = out_advance;
    byte_out_d   = mem[rd_addr_q];
    out_ready_d  = (fill_q != '0) && !out_advance;
    line_ready_d = (line_cnt_q != '0);
    ovf_d        = ovf_q;
    echo_char_d  = 8'h00;
    echo_valid_d = 1'b0;

    if (wr_en) begin
      wr_addr_d = wr_addr_q + ADDR_W'(1);
      last_cr_d = (byte_in == CR);
    end
    if (pop) rd_addr_d = rd_addr_q + ADDR_W'(1);

    case ({wr_en, pop})
      2'b10:   fill_d = fill_q + CNT_W'(1);
      2'b01:   fill_d = fill_q - CNT_W'(1);
      default: fill_d = fill_q;
    endcase

    case ({line_inc, line_dec})
      2'b10:   line_cnt_d = line_cnt_q + CNT_W'(1);
      2'b01:   line_cnt_d = line_cnt_q - CNT_W'(1);
      default: line_cnt_d = line_cnt_q;
    endcase

    if (ovf_drop)          ovf_d = 1'b1;
    else if (overflow_clr) ovf_d = 1'b0;

`ifdef UART_RX_ECHO_EN
    echo_valid_d = wr_en;
    echo_char_d  = wr_en ? byte_in : echo_char_q;
`else
    echo_valid_d = 1'b0;
    echo_char_d  = 8'h00;
`endif
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      fill_q       <= '0;
      line_cnt_q   <= '0;
      last_cr_q    <= 1'b0;
      adv_q        <= 1'b0;
      byte_out_q   <= 8'h00;
      out_ready_q  <= 1'b0;
      line_ready_q <= 1'b0;
      ovf_q        <= 1'b0;
      echo_char_q  <= 8'h00;
      echo_valid_q <= 1'b0;
    end else begin
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      fill_q       <= fill_d;
      line_cnt_q   <= line_cnt_d;
      last_cr_q    <= last_cr_d;
      adv_q        <= adv_d;
      byte_out_q   <= byte_out_d;
      out_ready_q  <= out_ready_d;
      line_ready_q <= line_ready_d;
      ovf_q        <= ovf_d;
      echo_char_q  <= echo_char_d;
      echo_valid_q <= echo_valid_d;
    end
  end

  // Storage array; contents survive reset
  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem[wr_addr_q] <= byte_in;
  end

  assign byte_out   = byte_out_q;
  assign out_ready  = out_ready_q;
  assign line_ready = line_ready_q;
  assign fill       = fill_q;
  assign overflow   = ovf_q;
  assign echo_char  = echo_char_q;
  assign echo_valid = echo_valid_q;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Self-checking bench for uart_rx_buffer (ADDR_W=2, depth 4) against a
// queue-based reference model.

module tb_uart_rx_buffer;

  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    byte_in = 8'h00;
  logic          in_valid = 1'b0;
  logic [7:0]    byte_out;
  logic          out_advance = 1'b0;
  logic          out_ready;
  logic          line_ready;
  logic [AW:0]   fill;
  logic          overflow;
  logic          overflow_clr = 1'b0;
  logic [7:0]    echo_char;
  logic          echo_valid;

`ifdef UART_RX_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  uart_rx_buffer #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .in_valid(in_valid),
    .byte_out(byte_out), .out_advance(out_advance), .out_ready(out_ready),
    .line_ready(line_ready), .fill(fill), .overflow(overflow),
    .overflow_clr(overflow_clr), .echo_char(echo_char), .echo_valid(echo_valid)
  );

  always #5 clk = ~clk;

  // Reference model
  logic [7:0] q[$];
  bit         m_ovf;
  bit         m_last_cr;
  int         total = 0;
  int         bad = 0;

  function automatic int cr_count();
    int n = 0;
    foreach (q[i]) if (q[i] == 8'h0D) n++;
    return n;
  endfunction

  function automatic bit model_write(input logic [7:0] b);
    if (m_last_cr && b == 8'h0A) return 1'b0;
    if (q.size() == DEPTH) begin
      m_ovf = 1'b1;
      return 1'b0;
    end
    q.push_back(b);
    m_last_cr = (b == 8'h0D);
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    q.delete();
    m_ovf = 1'b0;
    m_last_cr = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    bit acc;
    byte_in = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    acc = model_write(b);
    tick();
  endtask

  // Pops via a rising edge; got is byte_out as seen before the pop
  task automatic do_pop(output logic [7:0] got, output logic [7:0] exp, output bit had);
    got = byte_out;
    had = (q.size() > 0);
    exp = had ? q[0] : 8'h00;
    out_advance = 1'b1;
    tick();
    out_advance = 1'b0;
    tick();
    tick();
    if (had) void'(q.pop_front());
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    byte_in = 8'h33;
    tick();
    tick();
    in_valid = 1'b0;
    total++;
    if ({byte_out, out_ready, line_ready, fill, overflow, echo_char, echo_valid} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got bo=%h rdy=%b lr=%b fill=%0d ovf=%b ec=%h ev=%b, need all 0",
               byte_out, out_ready, line_ready, fill, overflow, echo_char, echo_valid);
    end
    rst = 1'b0;
    q.delete();
    m_ovf = 1'b0;
    m_last_cr = 1'b0;
    tick();
    total++;
    if (fill !== '0) begin bad++; $display("FAIL reset_fill_after: got %0d need 0", fill); end
  endtask

  task automatic test_basic();
    logic [7:0] g, e;
    bit h;
    do_reset();
    push(8'h41);
    push(8'h42);
    total++;
    if (fill !== 3'd2 || out_ready !== 1'b1) begin
      bad++; $display("FAIL basic_fill: got fill=%0d rdy=%b need 2 1", fill, out_ready);
    end
    for (int i = 0; i < 2; i++) begin
      do_pop(g, e, h);
      total++;
      if (g !== 8'h41 + 8'(i)) begin
        bad++; $display("FAIL basic_pop%0d: got %h need %h", i, g, 8'h41 + 8'(i));
      end
    end
    total++;
    if (fill !== 3'd0 || out_ready !== 1'b0) begin
      bad++; $display("FAIL basic_empty: got fill=%0d rdy=%b need 0 0", fill, out_ready);
    end
  endtask

  task automatic test_crlf();
    logic [7:0] g, e;
    bit h;
    do_reset();
    push(8'h68);
    push(8'h0D);
    push(8'h0A);
    total++;
    if (fill !== 3'd2 || line_ready !== 1'b1 || overflow !== 1'b0) begin
      bad++; $display("FAIL crlf_state: got fill=%0d lr=%b ovf=%b need 2 1 0", fill, line_ready, overflow);
    end
    do_pop(g, e, h);
    total++;
    if (g !== 8'h68 || line_ready !== 1'b1) begin
      bad++; $display("FAIL crlf_pop1: got %h lr=%b need 68 1", g, line_ready);
    end
    do_pop(g, e, h);
    total++;
    if (g !== 8'h0D || line_ready !== 1'b0) begin
      bad++; $display("FAIL crlf_pop2: got %h lr=%b need 0d 0", g, line_ready);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] g, e;
    bit h;
    do_reset();
    for (int i = 1; i <= 5; i++) push(8'(i));
    total++;
    if (fill !== 3'd4 || overflow !== 1'b1) begin
      bad++; $display("FAIL ovf_full: got fill=%0d ovf=%b need 4 1", fill, overflow);
    end
    // Drop and clear in the same cycle: the drop wins
    byte_in = 8'h06;
    in_valid = 1'b1;
    overflow_clr = 1'b1;
    tick();
    in_valid = 1'b0;
    overflow_clr = 1'b0;
    total++;
    if (overflow !== 1'b1 || fill !== 3'd4) begin
      bad++; $display("FAIL ovf_priority: got ovf=%b fill=%0d need 1 4", overflow, fill);
    end
    for (int i = 1; i <= 4; i++) begin
      do_pop(g, e, h);
      total++;
      if (g !== 8'(i)) begin bad++; $display("FAIL ovf_pop%0d: got %h need %h", i, g, 8'(i)); end
    end
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr: got %b need 0", overflow); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] g, e;
    bit h;
    do_reset();
    push(8'h11);
    push(8'h22);
    push(8'h33);
    g = byte_out;
    byte_in = 8'h44;
    in_valid = 1'b1;
    out_advance = 1'b1;
    tick();
    in_valid = 1'b0;
    out_advance = 1'b0;
    tick();
    tick();
    total++;
    if (fill !== 3'd3 || g !== 8'h11) begin
      bad++; $display("FAIL simul_fill: got fill=%0d head=%h need 3 11", fill, g);
    end
    for (int i = 0; i < 3; i++) begin
      do_pop(g, e, h);
      total++;
      if (g !== 8'h22 + 8'(i * 8'h11)) begin
        bad++; $display("FAIL simul_order%0d: got %h need %h", i, g, 8'h22 + 8'(i * 8'h11));
      end
    end
  endtask

  task automatic test_hold();
    do_reset();
    push(8'hAA);
    push(8'hBB);
    out_advance = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    out_advance = 1'b0;
    tick();
    tick();
    total++;
    if (fill !== 3'd1 || byte_out !== 8'hBB) begin
      bad++; $display("FAIL hold_one_pop: got fill=%0d head=%h need 1 bb", fill, byte_out);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] g, e;
    bit h;
    do_reset();
    push(8'h0D);
    push(8'h02);
    push(8'h03);
    rst = 1'b1;
    out_advance = 1'b1;
    overflow_clr = 1'b1;
    tick();
    rst = 1'b0;
    out_advance = 1'b0;
    overflow_clr = 1'b0;
    total++;
    if ({byte_out, out_ready, line_ready, fill, overflow, echo_char, echo_valid} !== '0) begin
      bad++;
      $display("FAIL midrst_outputs: got bo=%h rdy=%b lr=%b fill=%0d ovf=%b, need all 0",
               byte_out, out_ready, line_ready, fill, overflow);
    end
    q.delete();
    m_ovf = 1'b0;
    m_last_cr = 1'b0;
    push(8'h55);
    do_pop(g, e, h);
    total++;
    if (g !== 8'h55 || fill !== 3'd0) begin
      bad++; $display("FAIL midrst_readback: got %h fill=%0d need 55 0", g, fill);
    end
  endtask

  task automatic test_echo();
    bit acc;
    do_reset();
    byte_in = 8'h7A;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    acc = model_write(8'h7A);
    total++;
    if (echo_valid !== ECHO || echo_char !== (ECHO ? 8'h7A : 8'h00)) begin
      bad++; $display("FAIL echo_strobe: got ev=%b ec=%h need %b %h", echo_valid, echo_char,
                      ECHO, ECHO ? 8'h7A : 8'h00);
    end
    tick();
    total++;
    if (echo_valid !== 1'b0) begin bad++; $display("FAIL echo_one_cycle: got %b need 0", echo_valid); end
  endtask

  task automatic test_random();
    logic [7:0] g, e, b;
    bit h;
    int op;
    do_reset();
    for (int n = 0; n < 150; n++) begin
      op = int'($urandom_range(0, 9));
      if (op <= 4) begin
        case ($urandom_range(0, 3))
          0: b = 8'h0D;
          1: b = 8'h0A;
          default: b = 8'($urandom_range(0, 255));
        endcase
        push(b);
      end else if (op <= 7) begin
        do_pop(g, e, h);
        if (h) begin
          total++;
          if (g !== e) begin bad++; $display("FAIL rand_pop n=%0d: got %h need %h", n, g, e); end
        end
      end else if (op == 8) begin
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        m_ovf = 1'b0;
      end else begin
        tick();
      end
      total++;
      if (fill !== (AW + 1)'(q.size()) || out_ready !== (q.size() != 0) ||
          line_ready !== (cr_count() != 0) || overflow !== m_ovf) begin
        bad++;
        $display("FAIL rand_state n=%0d: got fill=%0d rdy=%b lr=%b ovf=%b need %0d %b %b %b",
                 n, fill, out_ready, line_ready, overflow, q.size(), q.size() != 0,
                 cr_count() != 0, m_ovf);
      end
      if (q.size() != 0) begin
        total++;
        if (byte_out !== q[0]) begin
          bad++; $display("FAIL rand_head n=%0d: got %h need %h", n, byte_out, q[0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_crlf();
    test_overflow();
    test_simultaneous();
    test_hold();
    test_reset_mid();
    test_echo();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_buffer.md
UART_RX_BUFFER -- requirements
Module: uart_rx_buffer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, FIFO address width; depth = 2^ADDR_W bytes.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port byte_in, input, 8, received byte from the UART receiver core.
REQ-005 SHALL have port in_valid, input, 1, one-cycle strobe qualifying byte_in.
REQ-006 SHALL have port byte_out, output reg, 8, byte at the FIFO head.
REQ-007 SHALL have port out_advance, input, 1, consumer pop request; level input, rising edge acts.
REQ-008 SHALL have port out_ready, output reg, 1, byte_out is valid.
REQ-009 SHALL have port line_ready, output reg, 1, at least one complete CR-terminated line is buffered.
REQ-010 SHALL have port fill, output reg, ADDR_W+1, current byte count.
REQ-011 SHALL have port overflow, output reg, 1, sticky: a byte was dropped.
REQ-012 SHALL have port overflow_clr, input, 1, clears overflow.
REQ-013 SHALL have port echo_char, output reg, 8, byte to echo to the TX buffer char_in.
REQ-014 SHALL have port echo_valid, output reg, 1, one-cycle strobe qualifying echo_char.

Function
REQ-015 SHALL accept the write when in_valid=1 and fill<2^ADDR_W: byte stored at write_addr, write_addr+1 (wraps mod 2^ADDR_W).
REQ-016 SHALL drop a byte of 0x0A when the previously accepted byte was 0x0D (CRLF collapses to CR); a dropped LF SHALL NOT set overflow.
REQ-017 SHALL drop in_valid bytes when fill=2^ADDR_W and set overflow=1 the next cycle.
REQ-018 SHALL pop on the detected rising edge (out_advance=1, previous-cycle out_advance=0) when fill!=0: read_addr+1, wrapping; pop when empty is ignored.
REQ-019 SHALL register byte_out <= buffer[read_addr] every cycle; a newly written byte into an empty FIFO appears on byte_out 2 cycles after in_valid.
REQ-020 SHALL register out_ready <= (fill!=0) && !out_advance.
REQ-021 SHALL update fill +1 on accepted write, -1 on pop, unchanged on simultaneous write and pop.
REQ-022 SHALL keep a line counter (ADDR_W+1 bits): +1 on accepted write of 0x0D, -1 on pop while byte_out=0x0D, unchanged when both occur; line_ready <= (counter!=0).
REQ-023 SHALL clear overflow when overflow_clr=1; a same-cycle drop takes priority (overflow stays 1).
REQ-024 SHALL never let fill exceed 2^ADDR_W nor go below 0.

Reset
REQ-025 SHALL on rst=1 clear write_addr, read_addr, fill, line counter, CR-tracking flag, out_advance delay register, byte_out, out_ready, line_ready, overflow, echo_char, echo_valid to 0; buffer contents are not cleared.
REQ-026 SHALL ignore in_valid, out_advance and overflow_clr in any cycle where rst=1; reset mid-stream discards all buffered data.

Configuration
REQ-027 SHALL, with UART_RX_ECHO_EN defined, drive echo_valid=1 and echo_char=byte_in the cycle after every accepted write (dropped bytes not echoed).
REQ-028 SHALL, without UART_RX_ECHO_EN, hold echo_valid=0 and echo_char=0 permanently; ports remain present.

Verification
REQ-029 SHALL cover: write 0x41,0x42 -> fill=2, out_ready=1; two out_advance rising edges -> byte_out 0x41 then 0x42, fill=0, out_ready=0.
REQ-030 SHALL cover: write 0x68,0x0D,0x0A -> fill=2 (LF dropped), line_ready=1; pop both -> line_ready=0.
REQ-031 SHALL cover: ADDR_W=2, write 5 bytes 0x01..0x05 -> fill=4, overflow=1, pops yield 0x01..0x04; overflow_clr -> overflow=0.
REQ-032 SHALL cover: fill=3, write and pop rising edge same cycle -> fill stays 3, data order preserved; out_advance held high 10 cycles -> exactly one pop.
REQ-033 SHALL cover: fill=3, rst pulse one cycle -> all outputs 0 next cycle, subsequent write 0x55 reads back 0x55.
REQ-034 SHALL cover: UART_RX_ECHO_EN defined, write 0x7A -> echo_valid=1, echo_char=0x7A one cycle later; undefined -> echo_valid stays 0.
